dcache_victim_ctrl: RTL and testbench

Request sequencer and replacement controller for the data cache, upstream of the `dcache_line` instances. It accepts CPU read/write requests and observes every line's hit/miss and TTL outputs. On a global miss it selects the victim line with the lowest TTL, pulses that line's `fill_req` and waits for the refill. It then replays the lookup and signals completion to the CPU.

---
 rtl/dcache_pkg.sv | 24 ++
 rtl/dcache_min_ttl.sv | 37 +++
 rtl/dcache_victim_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_dcache_victim_ctrl.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared types and defaults for the data-cache control slice (victim controller and dcache_line).
package dcache_pkg;

    localparam int unsigned TTL_BITS_DEF = 8;
    localparam int unsigned MAX_TTL_DEF  = 255;

    localparam int unsigned CNT_W   = 16;
    localparam int unsigned TMO_W   = 16;
    localparam int unsigned RETRY_W = 8;

    typedef enum logic [2:0] {
        StIdle,
        StLookup,
        StSelect,
        StFill,
        StWait,
        StRetry
    } ctrl_state_e;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/dcache_min_ttl.sv
// Combinational pairwise reduction returning the index of the smallest TTL.
// The lower index wins ties so victim choice is deterministic.
module dcache_min_ttl
    import dcache_pkg::*;
#(
    parameter int unsigned NLINES  = 4,
    parameter int unsigned TTLBITS = TTL_BITS_DEF,
    localparam int unsigned IDXW   = $clog2(NLINES)
) (
    input  logic [NLINES*TTLBITS-1:0] ttl,
    output logic [IDXW-1:0]           min_idx
);

    logic [TTLBITS-1:0] node_val [NLINES];
    logic [IDXW-1:0]    node_idx [NLINES];

    always_comb begin
        for (int i = 0; i < int'(NLINES); i++) begin
            node_val[i] = ttl[i*TTLBITS +: TTLBITS];
            node_idx[i] = IDXW'(i);
        end
        // Each level folds pairs in place; slot j only overwrites entries already consumed.
        for (int w = int'(NLINES) / 2; w >= 1; w = w / 2) begin
            for (int j = 0; j < w; j++) begin
                if (node_val[2*j+1] < node_val[2*j]) begin
                    node_val[j] = node_val[2*j+1];
                    node_idx[j] = node_idx[2*j+1];
                end else begin
                    node_val[j] = node_val[2*j];
                    node_idx[j] = node_idx[2*j];
                end
            end
        end
        min_idx = node_idx[0];
    end

endmodule

// File: rtl/dcache_victim_ctrl.sv
// Request sequencer and lowest-TTL victim selector in front of the dcache_line array.
// Issues single-cycle refill commands and reports hit or error completion to the CPU.
module dcache_victim_ctrl
    import dcache_pkg::*;
#(
    parameter int unsigned NLINES       = 4,
    parameter int unsigned TTLBITS      = TTL_BITS_DEF,
    parameter int unsigned MAXTTL       = MAX_TTL_DEF,
    parameter int unsigned FILL_TIMEOUT = 4095,
    parameter int unsigned MAX_RETRY    = 2,
    localparam int unsigned IDXW        = $clog2(NLINES)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      dcache_rdreq,
    input  logic                      dcache_wrreq,
    input  logic [NLINES-1:0]         line_valid,
    input  logic [NLINES-1:0]         line_miss,
    input  logic [NLINES*TTLBITS-1:0] line_ttl,
    output logic [NLINES-1:0]         fill_req,
    output logic [IDXW-1:0]           hit_sel,
    output logic                      cpu_stall,
    output logic                      cpu_done,
    output logic                      cpu_err,
    output logic                      multihit,
    output logic [CNT_W-1:0]          hit_cnt,
    output logic [CNT_W-1:0]          miss_cnt
);

    ctrl_state_e        state_q, state_d;
    logic [IDXW-1:0]    victim_q, victim_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic               armed_q, armed_d;
    logic [NLINES-1:0]  fill_req_q, fill_req_d;
    logic [IDXW-1:0]    hit_sel_q, hit_sel_d;
    logic               stall_q, stall_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               multihit_q, multihit_d;
    logic [CNT_W-1:0]   hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0]   miss_cnt_q, miss_cnt_d;

    logic [IDXW-1:0]    min_idx;
    logic [IDXW-1:0]    low_idx;
    logic [TTLBITS-1:0] victim_ttl;
    logic [TMO_W-1:0]   tmo_inc;
    logic [RETRY_W-1:0] retry_inc;
    logic               req;

    dcache_min_ttl #(
        .NLINES  (NLINES),
        .TTLBITS (TTLBITS)
    ) u_min_ttl (
        .ttl     (line_ttl),
        .min_idx (min_idx)
    );

    assign req        = dcache_rdreq | dcache_wrreq;
    assign victim_ttl = line_ttl[victim_q*TTLBITS +: TTLBITS];
    assign tmo_inc    = tmo_q + 1'b1;
    assign retry_inc  = retry_q + 1'b1;

    always_comb begin
        low_idx = '0;
        for (int i = int'(NLINES) - 1; i >= 0; i--) begin
            if (line_valid[i]) low_idx = IDXW'(i);
        end
    end

    always_comb begin
        state_d    = state_q;
        victim_d   = victim_q;
        tmo_d      = tmo_q;
        retry_d    = retry_q;
        armed_d    = armed_q;
        fill_req_d = '0;
        hit_sel_d  = hit_sel_q;
        stall_d    = stall_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        multihit_d = multihit_q;
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;

        unique case (state_q)
            StIdle: begin
                stall_d = 1'b0;
                // The CPU still holds its request during the completion pulse; skip that cycle.
                if (req && !done_q && !err_q) begin
                    stall_d = 1'b1;
                    retry_d = '0;
                    armed_d = 1'b0;
                    state_d = StLookup;
                end
            end
            StLookup: begin
                // Lines register their response a cycle after the request; skip the stale cycle.
                if (!armed_q) begin
                    armed_d = 1'b1;
                end else if (|line_valid) begin
                    done_d    = 1'b1;
                    hit_sel_d = low_idx;
                    hit_cnt_d = sat_inc(hit_cnt_q);
                    if ((line_valid & (line_valid - 1'b1)) != '0) multihit_d = 1'b1;
                    state_d = StIdle;
                end else if (&line_miss) begin
                    state_d = StSelect;
                end
            end
            StSelect: begin
                victim_d   = min_idx;
                fill_req_d = NLINES'(1) << min_idx;
                miss_cnt_d = sat_inc(miss_cnt_q);
                state_d    = StFill;
            end
            StFill: begin
                tmo_d   = '0;
                state_d = StWait;
            end
            StWait: begin
                if (victim_ttl == TTLBITS'(MAXTTL)) begin
                    state_d = StRetry;
                end else begin
                    tmo_d = tmo_inc;
                    if (tmo_inc == TMO_W'(FILL_TIMEOUT)) begin
                        err_d   = 1'b1;
                        state_d = StIdle;
                    end
                end
            end
            StRetry: begin
                retry_d = retry_inc;
                if (32'(retry_inc) > MAX_RETRY) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else begin
                    armed_d = 1'b0;
                    state_d = StLookup;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            victim_q   <= '0;
            tmo_q      <= '0;
            retry_q    <= '0;
            armed_q    <= 1'b0;
            fill_req_q <= '0;
            hit_sel_q  <= '0;
            stall_q    <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            multihit_q <= 1'b0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            victim_q   <= victim_d;
            tmo_q      <= tmo_d;
            retry_q    <= retry_d;
            armed_q    <= armed_d;
            fill_req_q <= fill_req_d;
            hit_sel_q  <= hit_sel_d;
            stall_q    <= stall_d;
            done_q     <= done_d;
            err_q      <= err_d;
            multihit_q <= multihit_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign fill_req  = fill_req_q;
    assign hit_sel   = hit_sel_q;
    assign cpu_stall = stall_q;
    assign cpu_done  = done_q;
    assign cpu_err   = err_q;
    assign multihit  = multihit_q;
    assign hit_cnt   = hit_cnt_q;
    assign miss_cnt  = miss_cnt_q;

endmodule

// File: tb/tb_dcache_victim_ctrl.sv
// Scoreboard bench for dcache_victim_ctrl: the stimulus side acts as CPU and cache lines and
// queues expected completions; a negedge monitor pops and compares whenever the DUT responds.
module tb_dcache_victim_ctrl;

    localparam int unsigned NL     = 4;
    localparam int unsigned MAXT   = 255;
    localparam int unsigned TMO    = 16;
    localparam int unsigned MRETRY = 2;

    typedef struct {
        bit is_err;
        int sel;
        int hcnt;
        int mcnt;
        bit mh;
        int lat_kind;  // 0 none, 1 from request, 2 from last fill_req
        int lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rdreq = 1'b0;
    logic        wrreq = 1'b0;
    logic [3:0]  lv = '0;
    logic [3:0]  lm = '0;
    logic [7:0]  ttl_arr [NL];
    logic [31:0] line_ttl;
    logic [3:0]  fill_req;
    logic [1:0]  hit_sel;
    logic        cpu_stall, cpu_done, cpu_err, multihit;
    logic [15:0] hit_cnt, miss_cnt;

    exp_t       exp_q [$];
    logic [3:0] fill_exp_q [$];
    exp_t       e_mon;

    int n_vec = 0;
    int n_fail = 0;
    int cyc = 0;
    int req_cyc = 0;
    int fill_cyc = 0;
    int m_hit = 0;
    int m_miss = 0;
    bit m_mh = 1'b0;
    bit stall_chk = 1'b0;
    bit abort = 1'b0;

    dcache_victim_ctrl #(
        .NLINES       (NL),
        .TTLBITS      (8),
        .MAXTTL       (MAXT),
        .FILL_TIMEOUT (TMO),
        .MAX_RETRY    (MRETRY)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .dcache_rdreq (rdreq),
        .dcache_wrreq (wrreq),
        .line_valid   (lv),
        .line_miss    (lm),
        .line_ttl     (line_ttl),
        .fill_req     (fill_req),
        .hit_sel      (hit_sel),
        .cpu_stall    (cpu_stall),
        .cpu_done     (cpu_done),
        .cpu_err      (cpu_err),
        .multihit     (multihit),
        .hit_cnt      (hit_cnt),
        .miss_cnt     (miss_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        line_ttl = '0;
        for (int i = 0; i < int'(NL); i++) line_ttl[i*8 +: 8] = ttl_arr[i];
    end

    function automatic void chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic int lowest(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return 0;
    endfunction

    function automatic int argmin();
        int best;
        best = 0;
        for (int i = 1; i < int'(NL); i++) if (ttl_arr[i] < ttl_arr[best]) best = i;
        return best;
    endfunction

    function automatic int sat16(input int v);
        return (v > 65535) ? 65535 : v;
    endfunction

    // Monitor: every DUT response is matched against the head of the expectation queues.
    always @(negedge clk) begin
        if (!reset) begin
            if (stall_chk) begin
                chk("stall_after_end", int'(cpu_stall), 0);
                stall_chk = 1'b0;
            end
            if (fill_req != '0) begin
                fill_cyc = cyc;
                if (fill_exp_q.size() == 0) chk("fill_req_unexpected", int'(fill_req), 0);
                else chk("fill_req", int'(fill_req), int'(fill_exp_q.pop_front()));
            end
            if (cpu_done || cpu_err) begin
                if (exp_q.size() == 0) begin
                    chk("completion_unexpected", int'({cpu_done, cpu_err}), 0);
                end else begin
                    e_mon = exp_q.pop_front();
                    chk("cpu_err", int'(cpu_err), int'(e_mon.is_err));
                    chk("cpu_done", int'(cpu_done), int'(!e_mon.is_err));
                    if (!e_mon.is_err) chk("hit_sel", int'(hit_sel), e_mon.sel);
                    chk("hit_cnt", int'(hit_cnt), e_mon.hcnt);
                    chk("miss_cnt", int'(miss_cnt), e_mon.mcnt);
                    chk("multihit", int'(multihit), int'(e_mon.mh));
                    chk("stall_at_end", int'(cpu_stall), 1);
                    if (e_mon.lat_kind == 1) chk("done_latency", cyc - req_cyc, e_mon.lat);
                    else if (e_mon.lat_kind == 2) chk("err_latency", cyc - fill_cyc, e_mon.lat);
                end
                stall_chk = 1'b1;
            end
        end
    end

    task automatic wait_sig(input bit want_end, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (want_end ? (cpu_done || cpu_err) : (fill_req != '0)) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_vec++;
            n_fail++;
            $display("FAIL wait_%s: no response within %0d cycles",
                     want_end ? "completion" : "fill_req", budget);
            abort = 1'b1;
        end
    endtask

    task automatic start_req();
        logic [1:0] r;
        r = 2'($urandom_range(1, 3));
        rdreq = r[0];
        wrreq = r[1];
        req_cyc = cyc;
    endtask

    task automatic end_req();
        rdreq = 1'b0;
        wrreq = 1'b0;
        lv = '0;
        lm = '0;
    endtask

    task automatic push_fill(input int idx);
        logic [3:0] oh;
        oh = 4'b0001 << idx;
        fill_exp_q.push_back(oh);
    endtask

    task automatic rand_ttls();
        for (int i = 0; i < int'(NL); i++) ttl_arr[i] = 8'($urandom_range(0, 254));
    endtask

    task automatic check_zero();
        chk("rst_fill_req", int'(fill_req), 0);
        chk("rst_hit_sel", int'(hit_sel), 0);
        chk("rst_cpu_stall", int'(cpu_stall), 0);
        chk("rst_cpu_done", int'(cpu_done), 0);
        chk("rst_cpu_err", int'(cpu_err), 0);
        chk("rst_multihit", int'(multihit), 0);
        chk("rst_hit_cnt", int'(hit_cnt), 0);
        chk("rst_miss_cnt", int'(miss_cnt), 0);
    endtask

    task automatic do_hit(input logic [3:0] hv, input bit delayed);
        exp_t e;
        bit   ok;
        @(negedge clk);
        if (delayed) begin
            lv = '0;
            lm = 4'($urandom_range(0, 14));
        end else begin
            lv = hv;
            lm = ~hv;
        end
        m_hit = sat16(m_hit + 1);
        m_mh = m_mh | ($countones(hv) > 1);
        e.is_err = 1'b0;
        e.sel = lowest(hv);
        e.hcnt = m_hit;
        e.mcnt = m_miss;
        e.mh = m_mh;
        e.lat_kind = delayed ? 0 : 1;
        e.lat = 3;
        exp_q.push_back(e);
        start_req();
        if (delayed) begin
            repeat ($urandom_range(2, 5)) @(negedge clk);
            lv = hv;
        end
        wait_sig(1'b1, 20, ok);
        end_req();
    endtask

    // nf refills are served; the lookup after the last one hits unless the retry limit is passed.
    task automatic do_miss(input int nf, input logic [3:0] hv, input int dly);
        exp_t e;
        bit   ok;
        int   vic;
        @(negedge clk);
        lv = '0;
        lm = 4'hF;
        e.is_err = (nf > int'(MRETRY));
        if (!e.is_err) begin
            m_hit = sat16(m_hit + 1);
            m_mh = m_mh | ($countones(hv) > 1);
        end
        m_miss = sat16(m_miss + nf);
        e.sel = lowest(hv);
        e.hcnt = m_hit;
        e.mcnt = m_miss;
        e.mh = m_mh;
        e.lat_kind = 0;
        e.lat = 0;
        push_fill(argmin());
        exp_q.push_back(e);
        start_req();
        for (int r = 1; r <= nf; r++) begin
            vic = argmin();
            wait_sig(1'b0, 30, ok);
            if (!ok) return;
            if ($urandom_range(0, 3) == 0) begin
                rdreq = 1'b0;
                wrreq = 1'b0;
            end
            repeat ((dly >= 0) ? dly : $urandom_range(1, 6)) @(negedge clk);
            ttl_arr[vic] = 8'(MAXT);
            if (r < nf) begin
                push_fill(argmin());
            end else if (!e.is_err) begin
                lv = hv;
                lm = '0;
            end
        end
        wait_sig(1'b1, 40, ok);
        end_req();
    endtask

    task automatic do_timeout();
        exp_t e;
        bit   ok;
        @(negedge clk);
        rand_ttls();
        lv = '0;
        lm = 4'hF;
        m_miss = sat16(m_miss + 1);
        e.is_err = 1'b1;
        e.sel = 0;
        e.hcnt = m_hit;
        e.mcnt = m_miss;
        e.mh = m_mh;
        e.lat_kind = 2;
        e.lat = int'(TMO) + 1;
        push_fill(argmin());
        exp_q.push_back(e);
        start_req();
        wait_sig(1'b0, 30, ok);
        if (!ok) return;
        wait_sig(1'b1, 40, ok);
        end_req();
    endtask

    task automatic do_reset_mid(input int rdly);
        bit ok;
        @(negedge clk);
        rand_ttls();
        lv = '0;
        lm = 4'hF;
        push_fill(argmin());
        start_req();
        wait_sig(1'b0, 30, ok);
        if (!ok) return;
        repeat (rdly) @(negedge clk);
        #2 reset = 1'b1;
        #1 check_zero();
        m_hit = 0;
        m_miss = 0;
        m_mh = 1'b0;
        end_req();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #500000;
        n_vec++;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        int         k;
        logic [3:0] hv;
        for (int i = 0; i < int'(NL); i++) ttl_arr[i] = '0;
        repeat (2) @(negedge clk);
        check_zero();
        reset = 1'b0;

        do_hit(4'b0100, 1'b0);
        ttl_arr[0] = 8'd10;
        ttl_arr[1] = 8'd3;
        ttl_arr[2] = 8'd3;
        ttl_arr[3] = 8'd200;
        if (!abort) do_miss(1, 4'b0010, 5);
        if (!abort) do_hit(4'b1010, 1'b0);
        if (!abort) do_hit(4'b0001, 1'b0);
        if (!abort) do_timeout();
        rand_ttls();
        if (!abort) do_miss(3, 4'b0001, -1);
        if (!abort) do_reset_mid(3);
        if (!abort) do_hit(4'b1000, 1'b0);
        if (!abort) do_reset_mid(0);

        for (int t = 0; t < 40 && !abort; t++) begin
            k = $urandom_range(0, 19);
            hv = 4'($urandom_range(1, 15));
            if (k < 9) begin
                do_hit(hv, $urandom_range(0, 2) == 0);
            end else if (k < 16) begin
                rand_ttls();
                do_miss($urandom_range(1, 3), hv, -1);
            end else if (k < 18) begin
                do_timeout();
            end else begin
                do_reset_mid($urandom_range(0, 1) * 3);
            end
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", exp_q.size() + fill_exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
